ram_arbiter: RTL

Shares the single-port synchronous main RAM (one-cycle read latency) between two requesters: the CPU bus and a video scanout fetcher. The block runs on the dot clock `clk`, issues at most one RAM access per cycle, favours video for scanout deadlines, and bounds CPU wait with a starvation cap. It sits between the CPU-side address decode and the `ram` instance, replacing the direct CPU-to-RAM connection.

---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arb_wait_ctr.sv | 32 +++
 rtl/ram_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter.
// Contents:
//   owner_t       - who owns the access currently in flight (OWN_NONE, OWN_CPU, OWN_VID)
//   DEF_ADDR_W    - default RAM word address width
//   DEF_DATA_W    - default RAM data width
//   WAIT_CNT_W    - width of the starvation counter (CPU_WAIT_MAX is at most 15)
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_t;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 8;
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/ram_arb_wait_ctr.sv
// Saturating starvation counter for the pending CPU request.
// Ports:
//   clk    - dot clock
//   reset  - synchronous active-high reset, clears the count
//   clr    - clear the count (CPU issued, or no CPU request)
//   inc    - CPU was eligible but lost arbitration this cycle
//   at_max - count has reached MAX; the CPU must win next time it is eligible
module ram_arb_wait_ctr
    import ram_arbiter_pkg::*;
#(
    parameter int MAX = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    logic [WAIT_CNT_W-1:0] cnt;

    assign at_max = (cnt == WAIT_CNT_W'(MAX));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing a single-port synchronous RAM (one-cycle read latency)
// between the CPU bus and the video scanout fetcher. Video normally wins;
// a CPU request that has lost CPU_WAIT_MAX times is forced through.
// Ports:
//   clk, reset                          - dot clock, synchronous active-high reset
//   cpu_req/we/addr/wdata               - CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata                  - CPU completion pulse and read data
//   vid_req, vid_addr, vid_gnt          - video read request handshake
//   vid_rvalid, vid_rdata               - video read return, one cycle after grant
//   ram_addr, ram_wdata, ram_we         - RAM command, driven from the winner
//   ram_rdata                           - RAM read data, one cycle after address
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CPU_WAIT_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    owner_t            owner;
    owner_t            win;
    logic              cpu_rd_q;
    logic [DATA_W-1:0] rdata_q;
    logic              cpu_elig;
    logic              at_max;

    // The CPU cannot re-issue in its own ack cycle, which limits it to
    // one access every second cycle.
    assign cpu_elig = cpu_req && (owner != OWN_CPU);

    ram_arb_wait_ctr #(
        .MAX (CPU_WAIT_MAX)
    ) u_wait_ctr (
        .clk    (clk),
        .reset  (reset),
        .clr    (!cpu_req || (win == OWN_CPU)),
        .inc    (cpu_elig && (win != OWN_CPU)),
        .at_max (at_max)
    );

    always_comb begin
        win       = OWN_NONE;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (!reset) begin
            if (cpu_elig && at_max) begin
                win = OWN_CPU;
            end else if (vid_req) begin
                win = OWN_VID;
            end else if (cpu_elig) begin
                win = OWN_CPU;
            end
        end
        case (win)
            OWN_CPU: begin
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_we    = cpu_we;
            end
            OWN_VID: begin
                ram_addr = vid_addr;
            end
            default: ;
        endcase
    end

    assign vid_gnt = (win == OWN_VID);

    // Completions of accesses issued just before reset are suppressed.
    assign cpu_ack    = (owner == OWN_CPU) && !reset;
    assign vid_rvalid = (owner == OWN_VID) && !reset;
    assign vid_rdata  = ram_rdata;

    // Read data is presented in the ack cycle and then held until the next read.
    assign cpu_rdata = (cpu_ack && cpu_rd_q) ? ram_rdata : rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= OWN_NONE;
            cpu_rd_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            owner <= win;
            if (win == OWN_CPU) begin
                cpu_rd_q <= !cpu_we;
            end
            if (cpu_ack && cpu_rd_q) begin
                rdata_q <= ram_rdata;
            end
        end
    end

endmodule
